// File: rtl/gcm_pkg.sv
// Shared GCM definitions for the GHASH engine.
//   BLK_W         : GCM block width (128)
//   GCM_POLY_LOW  : low-order terms of P(x) = x^128 + x^7 + x^2 + x + 1
//   state_t       : controller FSM states
//   reflect128    : bit reversal between GCM bit order and polynomial order
package gcm_pkg;

    localparam int         BLK_W        = 128;
    localparam logic [7:0] GCM_POLY_LOW = 8'h87;

    typedef enum logic [1:0] {IDLE, MUL, RED} state_t;

    // GCM stores the x^0 coefficient in bit 127; the datapath wants it in bit 0.
    function automatic logic [BLK_W-1:0] reflect128(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] r;
        for (int i = 0; i < BLK_W; i++) r[i] = x[BLK_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/gf128_reduce.sv
// Combinational reduction of a 255-bit carry-less product modulo
// P(x) = x^128 + x^7 + x^2 + x + 1.
//   prod : product bits 254:0, polynomial bit order
//   res  : reduced 128-bit field element, polynomial bit order
module gf128_reduce
    import gcm_pkg::*;
(
    input  logic [2*BLK_W-2:0] prod,
    output logic [BLK_W-1:0]   res
);

    // First fold of bits 254:128 can spill into bits 133:128 (shift by 7),
    // so it is kept 135 bits wide; the second fold lands below bit 14.
    logic [BLK_W+6:0] fold1;
    logic [6:0]       hi2;

    always_comb begin
        fold1 = {7'b0, prod[BLK_W-1:0]};
        for (int j = 0; j < 8; j++)
            if (GCM_POLY_LOW[j]) fold1 = fold1 ^ ({8'b0, prod[2*BLK_W-2:BLK_W]} << j);
        hi2 = fold1[BLK_W+6:BLK_W];
        res = fold1[BLK_W-1:0];
        for (int j = 0; j < 8; j++)
            if (GCM_POLY_LOW[j]) res = res ^ ({121'b0, hi2} << j);
    end

endmodule

// File: rtl/mul_128_module.sv
// Combinational 128x128 carry-less multiplier, one Karatsuba level over
// three 64x64 carry-less products.
//   a, b : operands, polynomial bit order (bit i = coeff x^i)
//   p    : product, degree <= 254 so 255 bits
module mul_128_module
    import gcm_pkg::*;
(
    input  logic [BLK_W-1:0]   a,
    input  logic [BLK_W-1:0]   b,
    output logic [2*BLK_W-2:0] p
);

    function automatic logic [126:0] clmul64(input logic [63:0] x, input logic [63:0] y);
        logic [126:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (y[i]) r = r ^ ({63'b0, x} << i);
        return r;
    endfunction

    logic [126:0] ll, hh, mm;

    assign ll = clmul64(a[63:0],   b[63:0]);
    assign hh = clmul64(a[127:64], b[127:64]);
    // (a_hi + a_lo)(b_hi + b_lo) - hh - ll gives the cross term in GF(2)
    assign mm = clmul64(a[127:64] ^ a[63:0], b[127:64] ^ b[63:0]) ^ hh ^ ll;

    assign p = {hh, 128'b0} ^ {64'b0, mm, 64'b0} ^ {128'b0, ll};

endmodule

// File: rtl/ghash_mul_ctrl.sv
// GHASH engine: folds each accepted block into Y <- (Y xor X) * H mod P(x).
//   clk, rst_n          : clock, async active-low reset
//   h_load, h_in        : capture hash key H (honoured in IDLE only)
//   init                : clear Y / abort an in-flight block
//   in_valid/in_ready   : block handshake, in_data = X, in_last = final block
//   tag_valid, tag_data : one-cycle tag pulse, tag_data holds until next tag
//   busy                : high from block acceptance until Y is updated
// The multiplier is a multicycle path: a and b are held for MUL_CYCLES
// cycles before the product is sampled.
module ghash_mul_ctrl
    import gcm_pkg::*;
#(
    parameter int MUL_CYCLES = 2,   // 1..15
    parameter int OUT_REG    = 1    // 1: register product before reduce
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_load,
    input  logic [BLK_W-1:0] h_in,
    input  logic             init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             tag_valid,
    output logic [BLK_W-1:0] tag_data,
    output logic             busy
);

    localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

    state_t             state;
    logic [BLK_W-1:0]   y, h, a, b;
    logic [3:0]         cnt;
    logic               last_q;
    logic [2*BLK_W-2:0] prod_c, prod_q, red_in;
    logic [BLK_W-1:0]   red_out, y_new;
    logic               y_upd;

    mul_128_module u_mul (.a(a), .b(b), .p(prod_c));

    assign red_in = (OUT_REG != 0) ? prod_q : prod_c;

    gf128_reduce u_red (.prod(red_in), .res(red_out));

    assign y_new = reflect128(red_out);

    // init in IDLE blocks acceptance in that same cycle
    assign in_ready = rst_n && (state == IDLE) && !init;

    assign y_upd = !init &&
                   ((state == RED) ||
                    (state == MUL && cnt == CNT_LAST && OUT_REG == 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            h         <= '0;
            a         <= '0;
            b         <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
            prod_q    <= '0;
            tag_valid <= 1'b0;
            tag_data  <= '0;
            busy      <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            if (state == IDLE && h_load) h <= h_in;

            case (state)
                IDLE: begin
                    if (init) begin
                        y <= '0;
                    end else if (in_valid) begin
                        a      <= reflect128(y ^ in_data);
                        b      <= reflect128(h);
                        last_q <= in_last;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (init) begin
                        y     <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == CNT_LAST && OUT_REG != 0) begin
                            prod_q <= prod_c;
                            state  <= RED;
                        end
                    end
                end
                RED: begin
                    if (init) begin
                        y     <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (y_upd) begin
                y     <= y_new;
                busy  <= 1'b0;
                state <= IDLE;
                if (last_q) begin
                    tag_valid <= 1'b1;
                    tag_data  <= y_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghash_mul_ctrl.sv
// Scoreboard bench for ghash_mul_ctrl: the driver pushes the expected tag and
// its arrival cycle on each handshake of a last block; a monitor pops and
// compares whenever tag_valid is seen.
module tb_ghash_mul_ctrl;

    localparam int MUL_CYCLES = 2;
    localparam int OUT_REG    = 1;
    localparam int LAT        = MUL_CYCLES + OUT_REG + 1;
    localparam logic [127:0] R_POLY = {8'he1, 120'h0};

    localparam logic [127:0] H_TV   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_TV   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T_TV   = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] H_ONE  = 128'h80000000000000000000000000000000;
    localparam logic [127:0] X1     = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] X2     = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] X12    = 128'hffffffffffffffffffffffffffffffff;

    typedef struct {
        logic [127:0] tag;
        int           cyc;
    } exp_t;

    logic         clk, rst_n, h_load, init, in_valid, in_last;
    logic         in_ready, tag_valid, busy;
    logic [127:0] h_in, in_data, tag_data;

    int           tests, errors;
    int           cyc;
    int           hs_count;
    logic [127:0] y_m, h_m;
    exp_t         exp_q[$];
    exp_t         e;

    ghash_mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .OUT_REG(OUT_REG)) dut (
        .clk(clk), .rst_n(rst_n), .h_load(h_load), .h_in(h_in), .init(init),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .tag_valid(tag_valid), .tag_data(tag_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) hs_count <= hs_count + 1;
    end

    // Right-shift GF(2^128) multiply in GCM bit order.
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        end
        return z;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every tag pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tag_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tag: got %h at cycle %0d, expected none", tag_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (tag_data !== e.tag || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL tag: got %h at cycle %0d, expected %h at cycle %0d",
                             tag_data, cyc, e.tag, e.cyc);
                end
            end
        end
    end

    task automatic load_h(input logic [127:0] v);
        h_load = 1'b1;
        h_in   = v;
        @(negedge clk);
        h_load = 1'b0;
        h_m    = v;
    endtask

    task automatic do_init(input bit with_valid);
        init = 1'b1;
        if (with_valid) begin
            in_valid = 1'b1;
            in_data  = X1;
        end
        #1 chk("ready_low_on_init", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        init     = 1'b0;
        in_valid = 1'b0;
        y_m      = '0;
    endtask

    // Called at a negedge. Returns at the negedge of the first MUL cycle when
    // full_chk=0, otherwise at the negedge of the cycle Y has been updated.
    task automatic send(input logic [127:0] d, input bit last, input bit push,
                        input bit use_model, input logic [127:0] exp,
                        input bit hold, input bit full_chk, output int hs_c);
        int waited;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests++;
            errors++;
            $display("FAIL handshake_timeout: in_ready low for %0d cycles, expected high", waited);
            in_valid = 1'b0;
            hs_c = -1;
            return;
        end
        hs_c = cyc;
        y_m  = gmul(y_m ^ d, h_m);
        if (last && push) exp_q.push_back('{use_model ? y_m : exp, hs_c + LAT});
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        if (!full_chk) return;
        for (int k = 1; k < LAT; k++) begin
            if (k > 1) @(negedge clk);
            chk("ready_low_busy", {126'b0, in_ready, busy}, 128'd1);
        end
        @(negedge clk);
        chk("ready_high_idle", {126'b0, in_ready, busy}, 128'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int hs, hs_prev, hs_base;
        tests = 0; errors = 0; cyc = 0; hs_count = 0;
        rst_n = 1'b0; h_load = 1'b0; init = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        h_in = '0; in_data = '0; y_m = '0; h_m = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        chk("rst_tag_valid", {127'b0, tag_valid}, 128'd0);
        chk("rst_tag_data", tag_data, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", {127'b0, in_ready}, 128'd1);
        @(negedge clk);

        // known-answer single block
        load_h(H_TV);
        do_init(1'b0);
        send(C_TV, 1'b1, 1'b1, 1'b0, T_TV, 1'b0, 1'b1, hs);

        // H = 1: tag is the xor of the blocks; simultaneous init/in_valid rejected
        load_h(H_ONE);
        do_init(1'b1);
        send(X1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);
        send(X2, 1'b1, 1'b1, 1'b0, X12, 1'b0, 1'b1, hs);

        // H = 0: tag is zero
        load_h('0);
        do_init(1'b0);
        send(128'hdeadbeefcafef00d0011223344556677, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);
        send(128'h8899aabbccddeeff1020304050607080, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);
        send(128'h00000000000000000000000000000001, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);

        // back-to-back, in_valid held, every block last so each result is checked
        load_h(H_TV);
        do_init(1'b0);
        hs_base = hs_count;
        hs_prev = -1;
        for (int i = 0; i < 4; i++) begin
            send({4{32'h1111_1111 * (i + 1)}} ^ C_TV, 1'b1, 1'b1, 1'b1, '0,
                 (i < 3), 1'b1, hs);
            if (hs_prev >= 0) chk("b2b_spacing", 128'(hs - hs_prev), 128'(LAT));
            hs_prev = hs;
        end
        repeat (3) @(negedge clk);
        chk("b2b_handshakes", 128'(hs_count - hs_base), 128'd4);

        // init abort in the second MUL cycle of block 2
        do_init(1'b0);
        send(X1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);
        send(X2, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, hs);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        y_m  = '0;
        #1 chk("abort_idle", {126'b0, in_ready, busy}, 128'd2);
        repeat (6) @(negedge clk);
        send(C_TV, 1'b1, 1'b1, 1'b0, T_TV, 1'b0, 1'b1, hs);

        // reset in MUL
        load_h(H_TV);
        do_init(1'b0);
        send(X1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, hs);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd0);
        chk("midrst_tag_valid", {127'b0, tag_valid}, 128'd0);
        chk("midrst_tag_data", tag_data, 128'd0);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        y_m   = '0;
        h_m   = '0;
        #1 chk("midrst_ready_after", {127'b0, in_ready}, 128'd1);
        // H was cleared: product is zero
        send(X2, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, hs);
        load_h(H_TV);
        send(C_TV, 1'b1, 1'b1, 1'b0, T_TV, 1'b0, 1'b1, hs);

        repeat (8) @(negedge clk);
        chk("pending_tags", 128'(exp_q.size()), 128'd0);
        chk("tag_data_hold", tag_data, T_TV);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
